// File: rtl/game_pkg.sv
// Shared game-level types and constants: the settings arbiter state encoding,
// the settings register map and the filler word returned on an aborted read.
package game_pkg;

    // Settings bus arbiter state encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } arb_state_t;

    // Settings / statistics register addresses on the read-only settings slave
    localparam logic [7:0] SETTINGS_ADR_BOARD_W     = 8'h00;
    localparam logic [7:0] SETTINGS_ADR_BOARD_H     = 8'h02;
    localparam logic [7:0] SETTINGS_ADR_MINES       = 8'h04;
    localparam logic [7:0] SETTINGS_ADR_TIME_LIMIT  = 8'h08;
    localparam logic [7:0] SETTINGS_ADR_GAMES_PLAY  = 8'h0A;
    localparam logic [7:0] SETTINGS_ADR_GAMES_WON   = 8'h0C;
    localparam logic [7:0] SETTINGS_ADR_BEST_TIME   = 8'h0E;
    localparam logic [7:0] SETTINGS_ADR_CUR_STREAK  = 8'h10;
    localparam logic [7:0] SETTINGS_ADR_BEST_STREAK = 8'h12;

    // Data word handed back when a read is abandoned
    localparam logic [15:0] SETTINGS_BAD_DATA = 16'hDEAD;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: returns the first requester that is requesting and not
// masked, searching upward from ptr with wrap-around. Purely combinational.
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Walk the requesters in priority order starting at ptr; the first eligible one wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_idx(ptr, i);
            if (!found && req[cand] && !mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/settings_bus_arbiter.sv
// Round-robin arbiter sharing the read-only settings Wishbone slave among
// NUM_REQ consumers. One read at a time: IDLE -> ISSUE -> CAPTURE -> RESPOND.
// Optional build macro SETTINGS_ARB_TIMEOUT_EN aborts a read stalled for
// TIMEOUT_CYCLES strobe cycles, answering SETTINGS_BAD_DATA with rsp_err=1.
module settings_bus_arbiter
    import game_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_adr,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [15:0]          rsp_dat,
    output logic                 rsp_err,
    output logic                 m_stb_o,
    output logic                 m_we_o,
    output logic [7:0]           m_adr_o,
    input  logic                 m_ack_i,
    input  logic                 m_stall_i,
    input  logic [15:0]          m_dat_i,
    output logic                 busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("settings_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [7:0]       adr_sel;
    logic             accepted;

    // A beat is taken only when the slave acks an unstalled strobe
    assign accepted = m_ack_i & ~m_stall_i;
    assign m_we_o   = 1'b0;
    assign busy     = (state != IDLE);

    // Requester currently pulsing rsp_valid is not eligible for a new grant
    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req),
        .mask  (rsp_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Address of the requester the picker selected, captured on grant
    always_comb begin
        adr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) adr_sel = req_adr[8*i +: 8];
        end
    end

`ifdef SETTINGS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             to_hit;
    logic             err_q;

    // The last allowed strobe cycle is the one where the counter shows TIMEOUT_CYCLES-1
    assign to_hit  = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Arbitration FSM with registered bus and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            m_stb_o   <= 1'b0;
            m_adr_o   <= '0;
            rsp_valid <= '0;
            rsp_dat   <= '0;
`ifdef SETTINGS_ARB_TIMEOUT_EN
            to_cnt    <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant   <= pick_idx;
                        m_adr_o <= adr_sel;
                        m_stb_o <= 1'b1;
                        state   <= ISSUE;
`ifdef SETTINGS_ARB_TIMEOUT_EN
                        to_cnt  <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (accepted) begin
                        m_stb_o <= 1'b0;
                        state   <= CAPTURE;
                    end
`ifdef SETTINGS_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        m_stb_o   <= 1'b0;
                        rsp_dat   <= SETTINGS_BAD_DATA;
                        err_q     <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << grant;
                        state     <= RESPOND;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                CAPTURE: begin
                    // Slave data is registered, so it is valid one cycle after ack
                    rsp_dat   <= m_dat_i;
                    rsp_valid <= NUM_REQ'(1) << grant;
                    state     <= RESPOND;
                end
                RESPOND: begin
                    rsp_valid <= '0;
                    ptr       <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    state     <= IDLE;
`ifdef SETTINGS_ARB_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_settings_bus_arbiter.sv
// Directed testbench for settings_bus_arbiter (default build, NUM_REQ=4).
// Includes a simple settings slave: combinational ack, registered read data.
module tb_settings_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_adr;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_dat;
    logic        rsp_err;
    logic        m_stb_o;
    logic        m_we_o;
    logic [7:0]  m_adr_o;
    logic        m_ack_i;
    logic        m_stall_i;
    logic [15:0] m_dat_i;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    settings_bus_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_adr   (req_adr),
        .rsp_valid (rsp_valid),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_adr_o   (m_adr_o),
        .m_ack_i   (m_ack_i),
        .m_stall_i (m_stall_i),
        .m_dat_i   (m_dat_i),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave register contents
    function automatic logic [15:0] slave_rom(input logic [7:0] a);
        case (a)
            8'h00:   return 16'h0009;
            8'h02:   return 16'h000A;
            8'h04:   return 16'h000C;
            8'h08:   return 16'h0063;
            default: return 16'h0000;
        endcase
    endfunction

    assign m_ack_i = m_stb_o & ~m_stall_i;

    initial m_dat_i = 16'h0000;
    always @(posedge clk) begin
        if (m_stb_o && !m_stall_i) m_dat_i <= slave_rom(m_adr_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Step until a response pulse appears; n = steps taken, bound+1 if none
    task automatic wait_rsp(input int bound, output int n);
        n = bound + 1;
        for (int k = 1; k <= bound; k++) begin
            step();
            if (rsp_valid !== 4'b0000) begin
                n = k;
                break;
            end
        end
    endtask

    int n;
    int stb_cycles;
    int adr_bad;
    int pulses;
    int busy_seen;

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        req_adr   = 32'h0;
        m_stall_i = 1'b0;

        // Reset state
        step();
        step();
        check("reset_stb", {31'b0, m_stb_o}, 0);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_rsp_valid", {28'b0, rsp_valid}, 0);
        check("reset_rsp_dat", {16'b0, rsp_dat}, 0);
        check("reset_rsp_err", {31'b0, rsp_err}, 0);
        check("reset_adr", {24'b0, m_adr_o}, 0);
        rst_n = 1'b1;
        step();

        // Single read by requester 1 at 0x02
        req          = 4'b0010;
        req_adr      = 32'h0000_0200;
        step();
        check("t1_stb_on", {31'b0, m_stb_o}, 1);
        check("t1_adr", {24'b0, m_adr_o}, 32'h02);
        check("t1_busy", {31'b0, busy}, 1);
        check("t1_we", {31'b0, m_we_o}, 0);
        step();
        check("t1_stb_one_cycle", {31'b0, m_stb_o}, 0);
        check("t1_no_early_rsp", {28'b0, rsp_valid}, 0);
        step();
        check("t1_rsp_valid", {28'b0, rsp_valid}, 32'b0010);
        check("t1_rsp_dat", {16'b0, rsp_dat}, 32'h000A);
        check("t1_rsp_err", {31'b0, rsp_err}, 0);
        req = 4'b0000;
        step();
        check("t1_pulse_one_cycle", {28'b0, rsp_valid}, 0);
        check("t1_idle", {31'b0, busy}, 0);
        check("t1_dat_held", {16'b0, rsp_dat}, 32'h000A);

        // Reset pulse so the pointer starts from 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // All four requesting: served 0,1,2,3, one per 4 cycles
        req     = 4'b1111;
        req_adr = 32'h0804_0200;
        wait_rsp(8, n);
        check("t2_lat0", n, 3);
        check("t2_grant0", {28'b0, rsp_valid}, 32'b0001);
        check("t2_dat0", {16'b0, rsp_dat}, 32'h0009);
        req = 4'b1110;
        wait_rsp(8, n);
        check("t2_lat1", n, 4);
        check("t2_grant1", {28'b0, rsp_valid}, 32'b0010);
        check("t2_dat1", {16'b0, rsp_dat}, 32'h000A);
        req = 4'b1100;
        wait_rsp(8, n);
        check("t2_lat2", n, 4);
        check("t2_grant2", {28'b0, rsp_valid}, 32'b0100);
        check("t2_dat2", {16'b0, rsp_dat}, 32'h000C);
        req = 4'b1000;
        wait_rsp(8, n);
        check("t2_lat3", n, 4);
        check("t2_grant3", {28'b0, rsp_valid}, 32'b1000);
        check("t2_dat3", {16'b0, rsp_dat}, 32'h0063);

        // Pointer wrapped to 0: requester 0 beats requester 3
        req = 4'b1001;
        wait_rsp(8, n);
        check("t2_wrap_grant0", {28'b0, rsp_valid}, 32'b0001);
        check("t2_wrap_dat0", {16'b0, rsp_dat}, 32'h0009);
        req = 4'b1000;
        wait_rsp(8, n);
        check("t2_wrap_grant3", {28'b0, rsp_valid}, 32'b1000);
        req = 4'b0000;
        step();

        // Requester 2 with a 20-cycle stall window
        req       = 4'b0100;
        m_stall_i = 1'b1;
        stb_cycles = 0;
        adr_bad    = 0;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (m_stb_o) begin
                stb_cycles++;
                if (m_adr_o !== 8'h04) adr_bad++;
            end
            if (i == 21) m_stall_i = 1'b0;
            if (i == 5) req_adr = 32'h0800_0200;
        end
        check("t3_stb_cycles", stb_cycles, 21);
        check("t3_adr_stable", adr_bad, 0);
        step();
        check("t3_grant2", {28'b0, rsp_valid}, 32'b0100);
        check("t3_dat2", {16'b0, rsp_dat}, 32'h000C);
        req = 4'b0000;
        step();
        check("t3_no_dup_busy", {31'b0, busy}, 0);
        check("t3_no_dup_rsp", {28'b0, rsp_valid}, 0);
        step();
        check("t3_still_idle", {31'b0, busy}, 0);

        // Requester 0 drops its request while stalled in ISSUE
        req_adr   = 32'h0804_0200;
        req       = 4'b0001;
        m_stall_i = 1'b1;
        step();
        check("t4_stb", {31'b0, m_stb_o}, 1);
        check("t4_adr", {24'b0, m_adr_o}, 32'h00);
        req = 4'b0000;
        step();
        step();
        step();
        m_stall_i = 1'b0;
        wait_rsp(6, n);
        check("t4_lat", n, 2);
        check("t4_grant0", {28'b0, rsp_valid}, 32'b0001);
        check("t4_dat0", {16'b0, rsp_dat}, 32'h0009);
        pulses    = 0;
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid !== 4'b0000) pulses++;
            if (busy) busy_seen++;
        end
        check("t4_not_reserved_rsp", pulses, 0);
        check("t4_not_reserved_busy", busy_seen, 0);

        // Reset asserted while requester 1 is in ISSUE
        req       = 4'b0010;
        m_stall_i = 1'b1;
        step();
        check("t5_stb_before", {31'b0, m_stb_o}, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_stb", {31'b0, m_stb_o}, 0);
        check("t5_async_busy", {31'b0, busy}, 0);
        step();
        check("t5_no_rsp", {28'b0, rsp_valid}, 0);
        req       = 4'b0011;
        m_stall_i = 1'b0;
        rst_n     = 1'b1;
        wait_rsp(8, n);
        check("t5_lat", n, 3);
        check("t5_ptr0_grant", {28'b0, rsp_valid}, 32'b0001);
        check("t5_dat0", {16'b0, rsp_dat}, 32'h0009);
        req = 4'b0010;
        wait_rsp(8, n);
        check("t5_grant1", {28'b0, rsp_valid}, 32'b0010);
        check("t5_dat1", {16'b0, rsp_dat}, 32'h000A);
        check("t5_err", {31'b0, rsp_err}, 0);
        req = 4'b0000;
        step();
        step();
        check("t5_final_idle", {31'b0, busy}, 0);
        check("t5_we", {31'b0, m_we_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety limit on total run time
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
